// File: rtl/stm1_deframer_if.sv
// rtl/stm1_deframer_if.sv - byte-in / payload-out bundle of the STM-1 deframer
interface stm1_deframer_if #(
    parameter int BYTE_W = 8
);
    logic [BYTE_W-1:0] in_data;
    logic              in_valid;
    logic [BYTE_W-1:0] out_data;
    logic              out_valid;
    logic              out_sof;
    logic              out_sor;
    logic [3:0]        out_row;
    logic [8:0]        out_col;
    logic              in_sync;
    logic              lof;
    logic              b1_err;

    modport master (
        output in_data, in_valid,
        input  out_data, out_valid, out_sof, out_sor, out_row, out_col,
        input  in_sync, lof, b1_err
    );

    modport slave (
        input  in_data, in_valid,
        output out_data, out_valid, out_sof, out_sor, out_row, out_col,
        output in_sync, lof, b1_err
    );
endinterface

// File: rtl/stm1_deframer.sv
// rtl/stm1_deframer.sv - STM-1 frame aligner and AU-4 payload extractor
// Optional BIP-8 (B1) check: define STM1_B1_CHECK_EN.
module stm1_deframer #(
    parameter int STM1_LENGTH    = 270,
    parameter int STM1_WIDTH     = 9,
    parameter int SOH_COLS       = 9,
    parameter int BYTE_W         = 8,
    parameter int FRAMES_TO_SYNC = 2,
    parameter int FRAMES_TO_LOSE = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    stm1_deframer_if.slave  bus
);
    localparam int                SR_W       = 6 * BYTE_W;
    localparam logic [BYTE_W-1:0] A1         = BYTE_W'(8'hF6);
    localparam logic [BYTE_W-1:0] A2         = BYTE_W'(8'h28);
    localparam logic [SR_W-1:0]   FRAME_WORD = {A1, A1, A1, A2, A2, A2};
    localparam logic [8:0]        COL_LAST   = 9'(STM1_LENGTH - 1);
    localparam logic [3:0]        ROW_LAST   = 4'(STM1_WIDTH - 1);
    localparam logic [8:0]        SOH_LIMIT  = 9'(SOH_COLS);
    localparam logic [8:0]        CHECK_COL  = 9'd5;
    localparam logic [8:0]        ALIGN_COL  = 9'd6;
    localparam logic [7:0]        SYNC_GOAL  = 8'(FRAMES_TO_SYNC);
    localparam logic [7:0]        LOSE_GOAL  = 8'(FRAMES_TO_LOSE);

    typedef enum logic [1:0] {
        HUNT    = 2'd0,
        PRESYNC = 2'd1,
        SYNC    = 2'd2
    } state_t;

    state_t            state, state_next;
    logic [7:0]        good_cnt, good_next;
    logic [7:0]        bad_cnt, bad_next;
    logic              lof_q, lof_next;
    logic              load_align;

    logic [3:0]        row;
    logic [8:0]        col;
    logic [SR_W-1:0]   sr;
    logic [SR_W-1:0]   sr_shift;
    logic              word_hit;
    logic              check_pos;
    logic              emit;

    logic [BYTE_W-1:0] out_data_q;
    logic              out_valid_q;
    logic              out_sof_q;
    logic              out_sor_q;
    logic [3:0]        out_row_q;
    logic [8:0]        out_col_q;

    // The match includes the byte arriving this cycle.
    assign sr_shift  = {sr[SR_W-BYTE_W-1:0], bus.in_data};
    assign word_hit  = (sr_shift == FRAME_WORD);
    assign check_pos = (row == 4'd0) && (col == CHECK_COL);
    assign emit      = bus.in_valid && (state == SYNC) && (col >= SOH_LIMIT);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= HUNT;
            good_cnt <= 8'd0;
            bad_cnt  <= 8'd0;
            lof_q    <= 1'b0;
        end else begin
            state    <= state_next;
            good_cnt <= good_next;
            bad_cnt  <= bad_next;
            lof_q    <= lof_next;
        end
    end

    always_comb begin
        state_next = state;
        good_next  = good_cnt;
        bad_next   = bad_cnt;
        lof_next   = lof_q;
        load_align = 1'b0;
        if (bus.in_valid) begin
            case (state)
                HUNT: begin
                    // Any position is accepted while hunting.
                    if (word_hit) begin
                        load_align = 1'b1;
                        if (SYNC_GOAL <= 8'd1) begin
                            state_next = SYNC;
                            good_next  = 8'd0;
                            bad_next   = 8'd0;
                            lof_next   = 1'b0;
                        end else begin
                            state_next = PRESYNC;
                            good_next  = 8'd1;
                        end
                    end
                end
                PRESYNC: begin
                    if (check_pos) begin
                        if (!word_hit) begin
                            state_next = HUNT;
                            good_next  = 8'd0;
                        end else if (good_cnt + 8'd1 >= SYNC_GOAL) begin
                            state_next = SYNC;
                            good_next  = 8'd0;
                            bad_next   = 8'd0;
                            lof_next   = 1'b0;
                        end else begin
                            good_next = good_cnt + 8'd1;
                        end
                    end
                end
                SYNC: begin
                    if (check_pos) begin
                        if (word_hit) begin
                            bad_next = 8'd0;
                        end else if (bad_cnt + 8'd1 >= LOSE_GOAL) begin
                            state_next = HUNT;
                            bad_next   = 8'd0;
                            lof_next   = 1'b1;
                        end else begin
                            bad_next = bad_cnt + 8'd1;
                        end
                    end
                end
                default: state_next = HUNT;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            row         <= 4'd0;
            col         <= 9'd0;
            sr          <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_sof_q   <= 1'b0;
            out_sor_q   <= 1'b0;
            out_row_q   <= 4'd0;
            out_col_q   <= 9'd0;
        end else begin
            out_valid_q <= emit;
            out_sof_q   <= emit && (row == 4'd0) && (col == SOH_LIMIT);
            out_sor_q   <= emit && (col == SOH_LIMIT);
            if (emit) begin
                out_data_q <= bus.in_data;
                out_row_q  <= row;
                out_col_q  <= col - SOH_LIMIT;
            end
            if (bus.in_valid) begin
                sr <= sr_shift;
                if (load_align) begin
                    row <= 4'd0;
                    col <= ALIGN_COL;
                end else if (col == COL_LAST) begin
                    col <= 9'd0;
                    row <= (row == ROW_LAST) ? 4'd0 : row + 4'd1;
                end else begin
                    col <= col + 9'd1;
                end
            end
        end
    end

`ifdef STM1_B1_CHECK_EN
    logic [BYTE_W-1:0] b1_acc;
    logic [BYTE_W-1:0] b1_latched;
    logic              b1_started;
    logic              b1_armed;
    logic              b1_err_q;

    // b1_armed means b1_latched covers a whole frame that began while in SYNC.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            b1_acc     <= '0;
            b1_latched <= '0;
            b1_started <= 1'b0;
            b1_armed   <= 1'b0;
            b1_err_q   <= 1'b0;
        end else begin
            b1_err_q <= 1'b0;
            if (state != SYNC) begin
                b1_started <= 1'b0;
                b1_armed   <= 1'b0;
            end
            if (bus.in_valid) begin
                if (row == 4'd0 && col == 9'd0) begin
                    b1_latched <= b1_acc;
                    b1_acc     <= bus.in_data;
                    if (state == SYNC) begin
                        b1_started <= 1'b1;
                        b1_armed   <= b1_started;
                    end
                end else begin
                    b1_acc <= b1_acc ^ bus.in_data;
                end
                if (state == SYNC && b1_armed && row == 4'd1 && col == 9'd0) begin
                    b1_err_q <= (bus.in_data != b1_latched);
                end
            end
        end
    end

    assign bus.b1_err = b1_err_q;
`else
    assign bus.b1_err = 1'b0;
`endif

    assign bus.out_data  = out_data_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_sof   = out_sof_q;
    assign bus.out_sor   = out_sor_q;
    assign bus.out_row   = out_row_q;
    assign bus.out_col   = out_col_q;
    assign bus.in_sync   = (state == SYNC);
    assign bus.lof       = lof_q;
endmodule

// File: tb/tb_stm1_deframer.sv
// tb/tb_stm1_deframer.sv - scoreboard bench for stm1_deframer with a frame-level model
module tb_stm1_deframer;
    localparam int LEN    = 270;
    localparam int ROWS   = 9;
    localparam int SOH    = 9;
    localparam int PAY    = LEN - SOH;
    localparam int FTS    = 2;
    localparam int FTL    = 4;
    localparam int S_HUNT = 0;
    localparam int S_PRE  = 1;
    localparam int S_SYNC = 2;
`ifdef STM1_B1_CHECK_EN
    localparam bit B1_ON = 1'b1;
`else
    localparam bit B1_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    stm1_deframer_if #(.BYTE_W(8)) bus ();

    stm1_deframer #(
        .STM1_LENGTH(LEN), .STM1_WIDTH(ROWS), .SOH_COLS(SOH), .BYTE_W(8),
        .FRAMES_TO_SYNC(FTS), .FRAMES_TO_LOSE(FTL)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    int checks = 0;
    int passes = 0;
    int pops = 0;
    int b1_pulses = 0;
    logic [22:0] exp_q[$];

    int  m_state = S_HUNT;
    int  m_good = 0;
    int  m_bad = 0;
    bit  m_lof = 1'b0;
    bit  gaps = 1'b0;
    logic [7:0] prev_xor = 8'h00;
    logic [7:0] cur_xor = 8'h00;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act === req) passes++;
        else $display("FAIL %s: got %0h expected %0h", name, act, req);
    endtask

    // Frame-level view of the aligner: one framing verdict per received frame.
    function void model_reset();
        m_state = S_HUNT;
        m_good  = 0;
        m_bad   = 0;
        m_lof   = 1'b0;
    endfunction

    function void model_frame(input bit ok);
        if (m_state == S_HUNT) begin
            if (ok) begin
                m_state = S_PRE;
                m_good  = 1;
            end
        end else if (m_state == S_PRE) begin
            if (!ok) m_state = S_HUNT;
            else begin
                m_good++;
                if (m_good >= FTS) begin
                    m_state = S_SYNC;
                    m_bad   = 0;
                    m_lof   = 1'b0;
                end
            end
        end else begin
            if (ok) m_bad = 0;
            else begin
                m_bad++;
                if (m_bad >= FTL) begin
                    m_state = S_HUNT;
                    m_lof   = 1'b1;
                end
            end
        end
    endfunction

    always @(negedge clk) begin
        if (bus.b1_err === 1'b1) b1_pulses++;
        if (bus.out_valid === 1'b1) begin
            if (exp_q.size() == 0) chk("unexpected_out_valid", 32'd1, 32'd0);
            else begin
                pops++;
                chk("payload{data,row,col,sof,sor}",
                    {9'd0, bus.out_data, bus.out_row, bus.out_col, bus.out_sof, bus.out_sor},
                    {9'd0, exp_q.pop_front()});
            end
        end
    end

    task automatic check_all_zero();
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_data", bus.out_data, 0);
        chk("rst_out_sof", bus.out_sof, 0);
        chk("rst_out_sor", bus.out_sor, 0);
        chk("rst_out_row", bus.out_row, 0);
        chk("rst_out_col", bus.out_col, 0);
        chk("rst_in_sync", bus.in_sync, 0);
        chk("rst_lof", bus.lof, 0);
        chk("rst_b1_err", bus.b1_err, 0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check_all_zero();
        chk("queue_drained_at_reset", exp_q.size(), 0);
        model_reset();
    endtask

    task automatic send_byte(input logic [7:0] b);
        if (gaps) begin
            while ($urandom_range(0, 1) == 1) begin
                bus.in_valid = 1'b0;
                @(posedge clk);
                #1;
            end
        end
        bus.in_data  = b;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic send_frame(input bit corrupt, input bit flip_b1, input int rst_at, input int offset);
        logic [7:0] b;
        cur_xor = 8'h00;
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < LEN; c++) begin
                if (r * LEN + c == rst_at) do_reset();
                if (c < SOH) begin
                    b = 8'h00;
                    if (r == 0 && c < 3) b = 8'hF6;
                    else if (r == 0 && c < 6) b = 8'h28;
                    if (r == 0 && c == 4 && corrupt) b = 8'h00;
                    if (r == 1 && c == 0) b = prev_xor ^ {7'd0, flip_b1};
                end else begin
                    b = 8'(r * PAY + (c - SOH) + offset);
                    if (m_state == S_SYNC)
                        exp_q.push_back({b, 4'(r), 9'(c - SOH), r == 0 && c == SOH, c == SOH});
                end
                cur_xor ^= b;
                send_byte(b);
                if (r == 0 && c == 5) begin
                    model_frame(!corrupt);
                    chk("in_sync_after_check", bus.in_sync, m_state == S_SYNC);
                    chk("lof_after_check", bus.lof, m_lof);
                end
                if (r == 1 && c == 0 && flip_b1) chk("b1_err_after_bad_b1", bus.b1_err, B1_ON);
            end
        end
        prev_xor = cur_xor;
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("%0d/%0d checks passed", passes, checks + 1);
        $fatal(1);
    end

    initial begin
        logic [7:0] g;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_all_zero();
        rst_n = 1'b1;

        // Clean frames from reset; frame 5 carries a B1 with bit 0 flipped.
        for (int f = 1; f <= 5; f++) begin
            send_frame(1'b0, f == 5, -1, 0);
            if (f == 3) begin
                @(negedge clk);
                #1;
                chk("bytes_through_frame3", pops, 2 * 2349);
            end
        end

        // Framing errors: 3 tolerated, 4 lose frame, then resync.
        repeat (3) send_frame(1'b1, 1'b0, -1, 7);
        send_frame(1'b0, 1'b0, -1, 11);
        repeat (4) send_frame(1'b1, 1'b0, -1, 13);
        repeat (2) send_frame(1'b0, 1'b0, -1, 17);

        // Random 50% in_valid gaps over four frames.
        gaps = 1'b1;
        repeat (4) send_frame(1'b0, 1'b0, -1, int'($urandom_range(0, 255)));
        gaps = 1'b0;

        // One-cycle reset at row 4 col 100, then two frames to resync.
        send_frame(1'b0, 1'b0, 4 * LEN + 100, 3);
        repeat (2) send_frame(1'b0, 1'b0, -1, 5);

        // Garbage without the framing word, then clean frames.
        do_reset();
        for (int i = 0; i < 1000; i++) begin
            g = 8'($urandom_range(0, 255));
            if (g == 8'hF6) g = 8'h00;
            send_byte(g);
        end
        chk("no_output_during_garbage", exp_q.size(), 0);
        repeat (2) send_frame(1'b0, 1'b0, -1, int'($urandom_range(0, 255)));

        @(negedge clk);
        #1;
        chk("queue_empty_at_end", exp_q.size(), 0);
        chk("b1_err_pulse_count", b1_pulses, B1_ON ? 1 : 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
